// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: mode codes,
// FSM state encoding and the signed saturation constant helper.
package addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  // Widest operand the saturation helper can describe.
  localparam int SAT_MAXW = 64;

  // Signed saturation constant for a 'width'-bit result:
  // neg=1 -> most negative value {1,0..0}, neg=0 -> most positive {0,1..1}.
  // Callers cast the return value down to their own width.
  function automatic logic [SAT_MAXW-1:0] sat_value(input int width, input logic neg);
    logic [SAT_MAXW-1:0] v;
    v = {SAT_MAXW{1'b0}};
    for (int i = 0; i < SAT_MAXW; i++) begin
      if (i < width - 1) begin
        v[i] = ~neg;
      end else if (i == width - 1) begin
        v[i] = neg;
      end else begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

endpackage

// File: rtl/addsub_serial_digit.sv
// Combinational DIGIT-bit ripple-carry slice. Besides the carry out it
// exposes the carry into the slice's top bit so the caller can form the
// signed overflow flag on the most significant digit.
module addsub_serial_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  // Ripple the carry through the slice bit by bit.
  always_comb begin
    logic c;
    c     = cin;
    sum   = {DIGIT{1'b0}};
    c_msb = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) begin
        c_msb = c;
      end else begin
        c_msb = c_msb;
      end
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    cout = c;
  end

endmodule

// File: rtl/addsub_serial.sv
// Digit-serial signed/unsigned adder-subtractor. Operands are latched on an
// accepted start, then consumed DIGIT bits per clock, LSB digit first. The
// sum digits are collected in an internal shift register; the visible
// result/co/ovf registers only update on the final digit, so they hold the
// previous answer for the whole run.
module addsub_serial
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             sat,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             co,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(NDIG - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;          // already inverted for subtract
  logic [WIDTH-1:0] acc_q, acc_d;      // internal sum shift register
  logic             carry_q, carry_d;
  logic             sat_q, sat_d;
  logic             a_sign_q, a_sign_d; // sign of operand_a, picks saturation side
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0]       sum_s;
  logic                   cout_s;
  logic                   cmsb_s;
  logic [WIDTH+DIGIT-1:0] cat_s;
  logic [WIDTH-1:0]       acc_next_s;
  logic                   ovf_s;

  addsub_serial_digit #(.DIGIT(DIGIT)) u_digit (
    .a     (a_q[DIGIT-1:0]),
    .b     (b_q[DIGIT-1:0]),
    .cin   (carry_q),
    .sum   (sum_s),
    .cout  (cout_s),
    .c_msb (cmsb_s)
  );

  // New digit enters the shift register from the top; the concatenation
  // keeps this legal when a single digit spans the whole word.
  assign cat_s      = {sum_s, acc_q};
  assign acc_next_s = cat_s[WIDTH+DIGIT-1:DIGIT];
  assign ovf_s      = cmsb_s ^ cout_s;

  // Next-state logic: FSM transitions, operand latch, digit step and final result.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    carry_d  = carry_q;
    sat_d    = sat_q;
    a_sign_d = a_sign_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    co_d     = co_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE, S_FIN: begin
        if (start) begin
          state_d  = S_RUN;
          cnt_d    = {CW{1'b0}};
          a_d      = operand_a;
          b_d      = (mode == MODE_SUB) ? ~operand_b : operand_b;
          carry_d  = (mode == MODE_SUB);
          sat_d    = sat;
          a_sign_d = operand_a[WIDTH-1];
          busy_d   = 1'b1;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        acc_d   = acc_next_s;
        carry_d = cout_s;
        if (cnt_q == CNT_LAST) begin
          state_d = S_FIN;
          cnt_d   = {CW{1'b0}};
          busy_d  = 1'b0;
          done_d  = 1'b1;
          co_d    = cout_s;
          ovf_d   = ovf_s;
          if (sat_q && ovf_s) begin
            result_d = WIDTH'(sat_value(WIDTH, a_sign_q));
          end else begin
            result_d = acc_next_s;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= {CW{1'b0}};
      a_q      <= {WIDTH{1'b0}};
      b_q      <= {WIDTH{1'b0}};
      acc_q    <= {WIDTH{1'b0}};
      carry_q  <= 1'b0;
      sat_q    <= 1'b0;
      a_sign_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= {WIDTH{1'b0}};
      co_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      carry_q  <= carry_d;
      sat_q    <= sat_d;
      a_sign_q <= a_sign_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      co_q     <= co_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign co     = co_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_addsub_serial.sv
// Bench for addsub_serial: directed 16-bit vector table, protocol corner
// sequences, and a full 4-bit sweep over DIGIT = 1, 2 and 4.
module tb_addsub_serial;
  import addsub_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // 16-bit DUT
  logic        start = 1'b0, mode = 1'b0, sat = 1'b0;
  logic [15:0] op_a = 16'h0000, op_b = 16'h0000;
  logic        busy, done, co, ovf;
  logic [15:0] result;

  addsub_serial #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .sat(sat),
    .operand_a(op_a), .operand_b(op_b),
    .busy(busy), .done(done), .result(result), .co(co), .ovf(ovf)
  );

  // 4-bit sweep DUTs sharing one stimulus
  logic            sw_start = 1'b0, sw_mode = 1'b0;
  logic [3:0]      sw_a = 4'h0, sw_b = 4'h0;
  logic [2:0]      sw_busy, sw_done, sw_co, sw_ovf;
  logic [2:0][3:0] sw_res;

  addsub_serial #(.WIDTH(4), .DIGIT(1)) u_sw1 (
    .clk(clk), .rst(rst), .start(sw_start), .mode(sw_mode), .sat(1'b0),
    .operand_a(sw_a), .operand_b(sw_b),
    .busy(sw_busy[0]), .done(sw_done[0]), .result(sw_res[0]), .co(sw_co[0]), .ovf(sw_ovf[0])
  );
  addsub_serial #(.WIDTH(4), .DIGIT(2)) u_sw2 (
    .clk(clk), .rst(rst), .start(sw_start), .mode(sw_mode), .sat(1'b0),
    .operand_a(sw_a), .operand_b(sw_b),
    .busy(sw_busy[1]), .done(sw_done[1]), .result(sw_res[1]), .co(sw_co[1]), .ovf(sw_ovf[1])
  );
  addsub_serial #(.WIDTH(4), .DIGIT(4)) u_sw4 (
    .clk(clk), .rst(rst), .start(sw_start), .mode(sw_mode), .sat(1'b0),
    .operand_a(sw_a), .operand_b(sw_b),
    .busy(sw_busy[2]), .done(sw_done[2]), .result(sw_res[2]), .co(sw_co[2]), .ovf(sw_ovf[2])
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        m;
    logic        s;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        co;
    logic        ovf;
  } vec_t;

  vec_t vecs [12];

  // One 16-bit operation: lat = edges from accept to done, bcyc = busy cycles.
  task automatic run16(input logic m, input logic s, input logic [15:0] a, input logic [15:0] b,
                       output int lat, output int bcyc);
    @(negedge clk);
    start = 1'b1; mode = m; sat = s; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0; op_a = ~a; op_b = ~b; mode = ~m;
    bcyc = busy ? 1 : 0;
    lat = 0;
    while (lat < 12) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
      if (busy) bcyc++;
    end
  endtask

  initial begin
    int lat, bcyc, k;
    logic seen;
    logic [2:0] got;
    int lat_tab [3];
    lat_tab = '{4, 2, 1};

    vecs[0]  = '{MODE_ADD, 1'b0, 16'h1234, 16'h0101, 16'h1335, 1'b0, 1'b0};
    vecs[1]  = '{MODE_SUB, 1'b0, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0};
    vecs[2]  = '{MODE_SUB, 1'b0, 16'h0007, 16'h0005, 16'h0002, 1'b1, 1'b0};
    vecs[3]  = '{MODE_ADD, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1};
    vecs[4]  = '{MODE_ADD, 1'b1, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b0, 1'b1};
    vecs[5]  = '{MODE_SUB, 1'b1, 16'h8000, 16'h0001, 16'h8000, 1'b1, 1'b1};
    vecs[6]  = '{MODE_SUB, 1'b0, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1};
    vecs[7]  = '{MODE_ADD, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0};
    vecs[8]  = '{MODE_ADD, 1'b1, 16'h8000, 16'h8000, 16'h8000, 1'b1, 1'b1};
    vecs[9]  = '{MODE_SUB, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[10] = '{MODE_ADD, 1'b1, 16'h4000, 16'h4000, 16'h7FFF, 1'b0, 1'b1};
    vecs[11] = '{MODE_SUB, 1'b0, 16'h7FFF, 16'hFFFF, 16'h8000, 1'b0, 1'b1};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_co", 32'(co), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed vector table
    for (int i = 0; i < 12; i++) begin
      run16(vecs[i].m, vecs[i].s, vecs[i].a, vecs[i].b, lat, bcyc);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("v%0d_busy_cycles", i), 32'(bcyc), 32'd4);
      check($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'd0);
      check($sformatf("v%0d_result", i), 32'(result), 32'(vecs[i].res));
      check($sformatf("v%0d_co", i), 32'(co), 32'(vecs[i].co));
      check($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
      @(posedge clk); #1;
      check($sformatf("v%0d_done_one_cycle", i), 32'(done), 32'd0);
      check($sformatf("v%0d_result_hold", i), 32'(result), 32'(vecs[i].res));
    end

    // Back-to-back: start held high through RUN into FIN
    @(negedge clk);
    start = 1'b1; mode = MODE_ADD; sat = 1'b0; op_a = 16'h1111; op_b = 16'h2222;
    @(posedge clk); #1;
    op_a = 16'h0F00; op_b = 16'h00F0; mode = MODE_SUB;
    lat = 0;
    while (lat < 12) begin
      @(posedge clk); #1; lat++;
      if (done) break;
    end
    check("b2b_first_latency", 32'(lat), 32'd4);
    check("b2b_first_result", 32'(result), 32'h3333);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_accept_busy", 32'(busy), 32'd1);
    check("b2b_accept_done_low", 32'(done), 32'd0);
    lat = 0;
    while (lat < 12) begin
      @(posedge clk); #1; lat++;
      if (done) break;
    end
    check("b2b_second_latency", 32'(lat), 32'd4);
    check("b2b_second_result", 32'(result), 32'h0E10);
    check("b2b_second_co", 32'(co), 32'd1);

    // start pulsed during RUN with new operands is ignored
    @(negedge clk);
    start = 1'b1; mode = MODE_ADD; sat = 1'b0; op_a = 16'h0F0F; op_b = 16'h0101;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op_a = 16'hFFFF; op_b = 16'hFFFF; mode = MODE_SUB;
    check("ign_result_hold", 32'(result), 32'h0E10);
    check("ign_co_hold", 32'(co), 32'd1);
    check("ign_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    lat = 2;
    while (lat < 12) begin
      @(posedge clk); #1; lat++;
      if (done) break;
    end
    check("ign_latency", 32'(lat), 32'd4);
    check("ign_result", 32'(result), 32'h1010);
    check("ign_co", 32'(co), 32'd0);
    repeat (3) @(posedge clk);
    #1;

    // Reset in RUN cycle 2 aborts without a done pulse
    @(negedge clk);
    start = 1'b1; mode = MODE_SUB; sat = 1'b0; op_a = 16'h0100; op_b = 16'h0001;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrst_pre_result", 32'(result), 32'h1010);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_co", 32'(co), 32'd0);
    check("midrst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    check("midrst_no_done", 32'(seen), 32'd0);
    run16(MODE_SUB, 1'b0, 16'h0100, 16'h0001, lat, bcyc);
    check("postrst_latency", 32'(lat), 32'd4);
    check("postrst_result", 32'(result), 32'h00FF);
    check("postrst_co", 32'(co), 32'd1);
    check("postrst_ovf", 32'(ovf), 32'd0);

    // 4-bit exhaustive sweep, DIGIT = 1, 2, 4
    for (int m = 0; m < 2; m++) begin
      for (int ai = -8; ai <= 7; ai++) begin
        for (int bi = -8; bi <= 7; bi++) begin
          logic [3:0] ua, ub, ubn;
          logic [4:0] f;
          int s_val;
          logic e_ovf;
          ua  = 4'(ai);
          ub  = 4'(bi);
          ubn = ~ub;
          if (m == 1) begin
            f     = {1'b0, ua} + {1'b0, ubn} + 5'd1;
            s_val = ai - bi;
          end else begin
            f     = {1'b0, ua} + {1'b0, ub};
            s_val = ai + bi;
          end
          e_ovf = (s_val < -8) || (s_val > 7);
          @(negedge clk);
          sw_start = 1'b1; sw_mode = (m == 1); sw_a = ua; sw_b = ub;
          @(posedge clk); #1;
          sw_start = 1'b0; sw_a = ~ua; sw_b = ~ub;
          got = 3'b000;
          for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
              if (sw_done[i]) begin
                got[i] = 1'b1;
                check($sformatf("sw_d%0d_m%0d_a%0d_b%0d_lat", lat_tab[3-1-i] == 0 ? 0 : (i == 0 ? 1 : (i == 1 ? 2 : 4)), m, ai, bi),
                      32'(c), 32'(lat_tab[i]));
                check($sformatf("sw_i%0d_m%0d_a%0d_b%0d_res", i, m, ai, bi), 32'(sw_res[i]), 32'(f[3:0]));
                check($sformatf("sw_i%0d_m%0d_a%0d_b%0d_co", i, m, ai, bi), 32'(sw_co[i]), 32'(f[4]));
                check($sformatf("sw_i%0d_m%0d_a%0d_b%0d_ovf", i, m, ai, bi), 32'(sw_ovf[i]), 32'(e_ovf));
              end
            end
          end
          check($sformatf("sw_m%0d_a%0d_b%0d_all_done", m, ai, bi), 32'(got), 32'h7);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
